vga_timing_params: RTL and testbench



---
 rtl/vga_timing_params.sv | 95 +++++++++
 tb/tb_vga_timing_params.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_params.sv
// VGA raster timing generator: free-running h/v counters with registered
// hsync, vsync, can_draw, start_of_frame and pixel coordinates x, y.
//
// Ports:
//   clk            pixel clock, rising edge
//   reset          synchronous, active-high
//   hsync, vsync   sync outputs, active level set by *_ACTIVE
//   can_draw       (x,y) lies inside the visible area
//   start_of_frame one-cycle pulse at pixel (0,0)
//   x, y           raw counts, blanking included
module vga_timing_params #(
  parameter int   H_VISIBLE    = 800,
  parameter int   H_FRONT      = 56,
  parameter int   H_SYNC       = 120,
  parameter int   H_BACK       = 64,
  parameter int   V_VISIBLE    = 600,
  parameter int   V_FRONT      = 37,
  parameter int   V_SYNC       = 6,
  parameter int   V_BACK       = 23,
  parameter logic HSYNC_ACTIVE = 1'b1,
  parameter logic VSYNC_ACTIVE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        hsync,
  output logic        vsync,
  output logic        can_draw,
  output logic        start_of_frame,
  output logic [10:0] x,
  output logic [10:0] y
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [10:0] h_next;
  logic [10:0] v_next;
  logic        h_wrap;
  logic        vis;
  logic        hs_on;
  logic        vs_on;
  logic        sof;

  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    h_next = h_wrap ? 11'd0 : h_cnt + 11'd1;
    v_next = v_cnt;
    if (h_wrap) begin
      v_next = (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
    end
  end

  // Decode the current counters; the result is registered below so every
  // output describes the same (h_cnt, v_cnt) pair one clock later.
  always_comb begin
    vis   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hs_on = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs_on = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    sof   = (h_cnt == 11'd0) && (v_cnt == 11'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt          <= 11'd0;
      v_cnt          <= 11'd0;
      x              <= 11'd0;
      y              <= 11'd0;
      can_draw       <= 1'b0;
      start_of_frame <= 1'b0;
      hsync          <= ~HSYNC_ACTIVE;
      vsync          <= ~VSYNC_ACTIVE;
    end else begin
      h_cnt          <= h_next;
      v_cnt          <= v_next;
      x              <= h_cnt;
      y              <= v_cnt;
      can_draw       <= vis;
      start_of_frame <= sof;
      hsync          <= hs_on ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
      vsync          <= vs_on ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
    end
  end

endmodule

// File: tb/tb_vga_timing_params.sv
// Bench for vga_timing_params: default SVGA instance plus a tiny
// active-low instance small enough to cover whole frames.
module tb_vga_timing_params;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        cd;
    logic        sof;
    logic [10:0] x;
    logic [10:0] y;
  } out_t;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_a = 1'b1;
  logic        hs_a, vs_a, cd_a, sof_a;
  logic [10:0] x_a, y_a;

  logic        rst_b = 1'b1;
  logic        hs_b, vs_b, cd_b, sof_b;
  logic [10:0] x_b, y_b;

  int n_chk  = 0;
  int n_fail = 0;

  vga_timing_params u_a (
    .clk            (clk),
    .reset          (rst_a),
    .hsync          (hs_a),
    .vsync          (vs_a),
    .can_draw       (cd_a),
    .start_of_frame (sof_a),
    .x              (x_a),
    .y              (y_a)
  );

  // 8+2+3+2 = 15 clocks per line, 5+2+2+1 = 10 lines, 150 clocks/frame
  vga_timing_params #(
    .H_VISIBLE    (8),
    .H_FRONT      (2),
    .H_SYNC       (3),
    .H_BACK       (2),
    .V_VISIBLE    (5),
    .V_FRONT      (2),
    .V_SYNC       (2),
    .V_BACK       (1),
    .HSYNC_ACTIVE (1'b0),
    .VSYNC_ACTIVE (1'b0)
  ) u_b (
    .clk            (clk),
    .reset          (rst_b),
    .hsync          (hs_b),
    .vsync          (vs_b),
    .can_draw       (cd_b),
    .start_of_frame (sof_b),
    .x              (x_b),
    .y              (y_b)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference raster decode, written from the timing description
  function automatic out_t ref_out(
    input int h, input int v,
    input int hv, input int hf, input int hsw,
    input int vv, input int vf, input int vsw,
    input logic hp, input logic vp);
    out_t o;
    o.x   = 11'(h);
    o.y   = 11'(v);
    o.cd  = (h < hv) && (v < vv);
    o.sof = (h == 0) && (v == 0);
    o.hs  = (h >= hv + hf && h < hv + hf + hsw) ? hp : ~hp;
    o.vs  = (v >= vv + vf && v < vv + vf + vsw) ? vp : ~vp;
    return o;
  endfunction

  out_t q_a[$];
  out_t q_b[$];
  int   mh_a = 0, mv_a = 0;
  int   mh_b = 0, mv_b = 0;

  // Push the expected outputs for each edge; reset is driven on negedges
  always @(posedge clk) begin
    out_t e;
    if (rst_a) begin
      e = '{hs: 1'b0, vs: 1'b0, cd: 1'b0, sof: 1'b0, x: 11'd0, y: 11'd0};
      mh_a = 0;
      mv_a = 0;
    end else begin
      e = ref_out(mh_a, mv_a, 800, 56, 120, 600, 37, 6, 1'b1, 1'b1);
      if (mh_a == 1039) begin
        mh_a = 0;
        mv_a = (mv_a == 665) ? 0 : mv_a + 1;
      end else begin
        mh_a = mh_a + 1;
      end
    end
    q_a.push_back(e);
    if (rst_b) begin
      e = '{hs: 1'b1, vs: 1'b1, cd: 1'b0, sof: 1'b0, x: 11'd0, y: 11'd0};
      mh_b = 0;
      mv_b = 0;
    end else begin
      e = ref_out(mh_b, mv_b, 8, 2, 3, 5, 2, 2, 1'b0, 1'b0);
      if (mh_b == 14) begin
        mh_b = 0;
        mv_b = (mv_b == 9) ? 0 : mv_b + 1;
      end else begin
        mh_b = mh_b + 1;
      end
    end
    q_b.push_back(e);
  end

  always @(negedge clk) begin
    out_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      chk("sb_a", 32'({hs_a, vs_a, cd_a, sof_a, x_a, y_a}), 32'(e));
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      chk("sb_b", 32'({hs_b, vs_b, cd_b, sof_b, x_b, y_b}), 32'(e));
    end
  end

  task automatic run_a();
    int cd_n = 0, cd_off = -1;
    int hs_n = 0, hs_first = -1, hs_last = -1;
    int sof_n = 0;
    int k;
    repeat (1) @(negedge clk);
    chk("a_rst_x", x_a, 0);
    chk("a_rst_cd", cd_a, 0);
    chk("a_rst_sof", sof_a, 0);
    chk("a_rst_hs", hs_a, 0);
    chk("a_rst_vs", vs_a, 0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    for (int i = 0; i <= 1040; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("a_first_xy", {x_a, y_a}, 0);
        chk("a_first_cd", cd_a, 1);
        chk("a_first_sof", sof_a, 1);
        chk("a_first_sync", {hs_a, vs_a}, 0);
      end
      if (i == 1) begin
        chk("a_second_x", x_a, 1);
        chk("a_second_sof", sof_a, 0);
      end
      if (i > 0 && sof_a) sof_n++;
      if (i < 1040) begin
        if (cd_a) cd_n++;
        else if (cd_off < 0) cd_off = int'(x_a);
        if (hs_a) begin
          hs_n++;
          if (hs_first < 0) hs_first = int'(x_a);
          hs_last = int'(x_a);
        end
      end else begin
        chk("a_wrap_x", x_a, 0);
        chk("a_wrap_y", y_a, 1);
      end
    end
    chk("a_cd_count", cd_n, 800);
    chk("a_cd_off_x", cd_off, 800);
    chk("a_hs_count", hs_n, 120);
    chk("a_hs_first", hs_first, 856);
    chk("a_hs_last", hs_last, 975);
    chk("a_no_sof", sof_n, 0);
    k = 0;
    while (x_a != 11'd500 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("a_reach_500", x_a, 500);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    chk("a_mid_rst_xy", {x_a, y_a}, 0);
    chk("a_mid_rst_flags", {hs_a, vs_a, cd_a, sof_a}, 0);
    @(negedge clk);
    chk("a_restart_xy", {x_a, y_a}, 0);
    chk("a_restart_sof", sof_a, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_b();
    int sof_at[$];
    int hs_n = 0, vs_n = 0, cd_n = 0;
    int vs_first = -1, vs_last = -1;
    int xmax = 0, ymax = 0;
    logic [10:0] px = 0, py = 0;
    int k;
    repeat (3) @(negedge clk);
    chk("b_rst_sync", {hs_b, vs_b}, 3);
    rst_b = 1'b0;
    for (int i = 0; i < 450; i++) begin
      @(negedge clk);
      if (sof_b) begin
        sof_at.push_back(i);
        if (i > 0) chk("b_pre_sof_xy", {px, py}, {11'd14, 11'd9});
      end
      if (i < 150) begin
        if (!hs_b) hs_n++;
        if (cd_b) cd_n++;
        if (!vs_b) begin
          vs_n++;
          if (vs_first < 0) vs_first = int'(y_b);
          vs_last = int'(y_b);
        end
        if (!hs_b) chk("b_hs_x", (x_b >= 10 && x_b <= 12), 1);
        if (y_b >= 5) chk("b_cd_vblank", cd_b, 0);
      end
      if (int'(x_b) > xmax) xmax = int'(x_b);
      if (int'(y_b) > ymax) ymax = int'(y_b);
      px = x_b;
      py = y_b;
    end
    chk("b_sof_count", sof_at.size(), 3);
    if (sof_at.size() == 3) begin
      chk("b_sof_first", sof_at[0], 0);
      chk("b_period_1", sof_at[1] - sof_at[0], 150);
      chk("b_period_2", sof_at[2] - sof_at[1], 150);
    end
    chk("b_hs_count", hs_n, 30);
    chk("b_vs_count", vs_n, 30);
    chk("b_vs_lines", {16'(vs_first), 16'(vs_last)}, {16'd7, 16'd8});
    chk("b_cd_count", cd_n, 40);
    chk("b_xmax", xmax, 14);
    chk("b_ymax", ymax, 9);
    k = 0;
    while (!(x_b == 11'd6 && y_b == 11'd4) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("b_reach_6_4", {x_b, y_b}, {11'd6, 11'd4});
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    chk("b_mid_rst", {hs_b, vs_b, cd_b, sof_b, x_b, y_b}, 26'h3000000);
    @(negedge clk);
    chk("b_restart", {cd_b, sof_b, x_b, y_b}, 24'hC00000);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
